// File: rtl/comp_vacc_readout_if.sv
// comp_vacc_readout_if
//   Output stream of the accumulator readout controller.
//   Each beat carries one antenna pair's data and its (a, b) indices.
//   master : m_data, m_ant_a, m_ant_b, m_valid, m_last out; m_ready in
//   slave  : the mirror image, used by the downstream correlator/packetiser
interface comp_vacc_readout_if #(
  parameter int ACC_WIDTH       = 12,
  parameter int VECTOR_LEN_BITS = 5
);
  logic [2*ACC_WIDTH-1:0]     m_data;
  logic [VECTOR_LEN_BITS-1:0] m_ant_a;
  logic [VECTOR_LEN_BITS-1:0] m_ant_b;
  logic                       m_valid;
  logic                       m_ready;
  logic                       m_last;

  modport master (
    output m_data, m_ant_a, m_ant_b, m_valid, m_last,
    input  m_ready
  );

  modport slave (
    input  m_data, m_ant_a, m_ant_b, m_valid, m_last,
    output m_ready
  );
endinterface

// File: rtl/comp_vacc_readout.sv
// comp_vacc_readout
//   Readout controller for the double-buffered compressed vector accumulator.
//   On buf_done it walks every antenna pair (a, b) with a <= b of the finished
//   buffer. It drives the BRAM read addresses, tracks the fixed read latency
//   with a shift register and streams {dout_a, dout_b} out of a skid FIFO.
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   buf_done, buf_done_idx  : buffer-complete pulse and its buffer index
//   ant_sel_a/_b, buf_sel   : registered read addresses and buffer select
//   dout_a/_b               : BRAM read data, RD_LATENCY after the address
//   m_if                    : output stream (data, antenna indices, last)
//   busy, overrun           : readout active; buf_done-while-busy pulse
module comp_vacc_readout #(
  parameter  int ACC_WIDTH       = 12,
  parameter  int VECTOR_LENGTH   = 32,
  parameter  int RD_LATENCY      = 2,
  localparam int VECTOR_LEN_BITS = $clog2(VECTOR_LENGTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       buf_done,
  input  logic                       buf_done_idx,
  output logic [VECTOR_LEN_BITS-1:0] ant_sel_a,
  output logic [VECTOR_LEN_BITS-1:0] ant_sel_b,
  output logic                       buf_sel,
  input  logic [ACC_WIDTH-1:0]       dout_a,
  input  logic [ACC_WIDTH-1:0]       dout_b,
  comp_vacc_readout_if.master        m_if,
  output logic                       busy,
  output logic                       overrun
);
  localparam int DEPTH = RD_LATENCY + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IFL_W = $clog2(RD_LATENCY + 2);
  localparam logic [VECTOR_LEN_BITS-1:0] LAST_IDX = VECTOR_LEN_BITS'(VECTOR_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic                       vld;
    logic [VECTOR_LEN_BITS-1:0] a;
    logic [VECTOR_LEN_BITS-1:0] b;
    logic                       last;
  } tag_t;

  typedef struct packed {
    logic [2*ACC_WIDTH-1:0]     data;
    logic [VECTOR_LEN_BITS-1:0] a;
    logic [VECTOR_LEN_BITS-1:0] b;
    logic                       last;
  } ent_t;

  state_t                     state_q, state_d;
  logic [VECTOR_LEN_BITS-1:0] a_q, a_d, b_q, b_d;   // next pair to issue
  logic                       buf_sel_q, buf_sel_d;
  logic                       overrun_q, overrun_d;
  tag_t                       iss_q, iss_d;         // issue register, drives the address outputs
  tag_t                       pipe_q [RD_LATENCY];
  tag_t                       pipe_d [RD_LATENCY];
  ent_t                       fifo_q [DEPTH];
  ent_t                       fifo_d [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           fifo_cnt_q, fifo_cnt_d;

  logic                       push, pop, credit, pair_last;
  logic [IFL_W-1:0]           inflight;
  int                         occ;
  ent_t                       head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head      = fifo_q[rd_ptr_q];
  assign pop       = (fifo_cnt_q != '0) && m_if.m_ready;
  assign push      = pipe_q[RD_LATENCY-1].vld;
  assign pair_last = (a_q == LAST_IDX) && (b_q == LAST_IDX);

  // Credit counts the slot freed by this cycle's pop; without it the loop
  // (issue register + pipe + FIFO head) would bubble every DEPTH beats.
  always_comb begin
    inflight = IFL_W'(iss_q.vld);
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + IFL_W'(pipe_q[i].vld);
    end
    occ    = int'(fifo_cnt_q) + int'(inflight) - int'(pop);
    credit = occ < DEPTH;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    buf_sel_d = buf_sel_q;
    iss_d     = iss_q;
    iss_d.vld = 1'b0;
    overrun_d = buf_done && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        // Pair (0,0) is issued on the accepting edge so the first address
        // appears in the cycle right after buf_done is sampled.
        if (buf_done) begin
          buf_sel_d = buf_done_idx;
          iss_d     = '{vld: 1'b1, a: '0, b: '0, last: 1'b0};
          a_d       = '0;
          b_d       = VECTOR_LEN_BITS'(1);
          state_d   = READ;
        end
      end
      READ: begin
        if (credit) begin
          iss_d = '{vld: 1'b1, a: a_q, b: b_q, last: pair_last};
          if (pair_last) begin
            state_d = DRAIN;
          end else if (b_q == LAST_IDX) begin
            a_d = a_q + 1'b1;
            b_d = a_q + 1'b1;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && head.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pipe_d[0] = iss_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{data: {dout_a, dout_b},
                           a:    pipe_q[RD_LATENCY-1].a,
                           b:    pipe_q[RD_LATENCY-1].b,
                           last: pipe_q[RD_LATENCY-1].last};
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      buf_sel_q  <= 1'b0;
      overrun_q  <= 1'b0;
      iss_q      <= '0;
      pipe_q     <= '{default: '0};
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      buf_sel_q  <= buf_sel_d;
      overrun_q  <= overrun_d;
      iss_q      <= iss_d;
      pipe_q     <= pipe_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign ant_sel_a      = iss_q.a;
  assign ant_sel_b      = iss_q.b;
  assign buf_sel        = buf_sel_q;
  assign busy           = (state_q != IDLE);
  assign overrun        = overrun_q;
  assign m_if.m_valid   = (fifo_cnt_q != '0);
  assign m_if.m_data    = head.data;
  assign m_if.m_ant_a   = head.a;
  assign m_if.m_ant_b   = head.b;
  assign m_if.m_last    = (fifo_cnt_q != '0) && head.last;
endmodule

// File: doc/comp_vacc_readout.md
# comp_vacc_readout

Readout controller for the double-buffered compressed vector accumulator. When the accumulator reports that a buffer is complete, this block walks every antenna pair (a, b) with a ≤ b. It drives the accumulator's read-port addresses and buffer select, and absorbs the fixed BRAM read latency in a small skid FIFO. It then streams {dout_a, dout_b} with antenna indices over a valid/ready interface to the downstream correlator/packetiser.

## Interface

Parameters:
- ACC_WIDTH, 12: width of each accumulator output word (INPUT_WIDTH + ACC_LEN_BITS).
- VECTOR_LENGTH, 32: antennas per vector; power of two, ≥ 2. VECTOR_LEN_BITS = log2(VECTOR_LENGTH).
- RD_LATENCY, 2: cycles from ant_sel/buf_sel presented to dout valid.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: reset. Asynchronous, active-low.
- buf_done, in, 1: one-cycle pulse; the accumulator finished filling a buffer.
- buf_done_idx, in, 1: index of the completed buffer; sampled with buf_done.
- ant_sel_a, out, VECTOR_LEN_BITS: read address, port A.
- ant_sel_b, out, VECTOR_LEN_BITS: read address, port B.
- buf_sel, out, 1: buffer being read.
- dout_a, in, ACC_WIDTH: accumulator data, port A.
- dout_b, in, ACC_WIDTH: accumulator data, port B.
- m_data, out, 2*ACC_WIDTH: {dout_a, dout_b}.
- m_ant_a, out, VECTOR_LEN_BITS: antenna index a of the current beat.
- m_ant_b, out, VECTOR_LEN_BITS: antenna index b of the current beat.
- m_valid, out, 1: beat valid.
- m_ready, in, 1: downstream accepts beat.
- m_last, out, 1: final pair of the buffer.
- busy, out, 1: readout in progress.
- overrun, out, 1: one-cycle pulse; buf_done arrived while busy.

## Operation

States:
- IDLE: waits for buf_done. On buf_done, the block registers buf_sel ← buf_done_idx and sets a = b = 0, then goes to READ.
- READ: issues one read (ant_sel_a = a, ant_sel_b = b) in every cycle that has credit. Credit exists when FIFO occupancy plus in-flight reads < FIFO depth.
  - Pair advance: if b == VECTOR_LENGTH−1, then a ← a+1 and b ← a+1; otherwise b ← b+1.
  - After issuing (VECTOR_LENGTH−1, VECTOR_LENGTH−1), go to DRAIN.
- DRAIN: no new reads. Go to IDLE after the handshake (m_valid & m_ready) of the m_last beat.

Read pipeline and FIFO:
- An RD_LATENCY-deep shift register tracks in-flight reads. Each entry holds a valid bit, a, b, and a last flag.
- When the shift register output is valid, {dout_a, dout_b}, a, b and last are written to the skid FIFO.
- FIFO depth is RD_LATENCY+2. It never overflows by construction, and full throughput is sustained with m_ready held high.

Stream rules:
- Beats per buffer: VECTOR_LENGTH·(VECTOR_LENGTH+1)/2 (528 at default), in lexicographic (a, b) order.
- m_data, m_ant_a, m_ant_b and m_last hold stable while m_valid & !m_ready.
- m_last is high only on (N−1, N−1).

Status and events:
- busy = (state ≠ IDLE).
- buf_done while busy is ignored, and overrun pulses for one cycle. The readout in progress continues unchanged.
- buf_sel holds its value in IDLE.
- The block does no arithmetic on data; words pass through bit-exact.

## Timing

- Reset (rst_n low) is asynchronous: state → IDLE, FIFO and in-flight register emptied, counters cleared.
- Output reset values: ant_sel_a = ant_sel_b = 0, buf_sel = 0, m_valid = 0, m_last = 0, m_data = 0, m_ant_a = m_ant_b = 0, busy = 0, overrun = 0.
- Reset mid-readout: m_valid drops immediately. No partial buffer resumes; the next buf_done restarts at (0, 0).
- buf_done sampled at edge T:
  - busy = 1 and first addresses presented in cycle T+1.
  - dout valid in cycle T+1+RD_LATENCY.
  - First m_valid in cycle T+2+RD_LATENCY (T+4 at default).
- With m_ready constantly high: one beat per cycle, no bubbles after the first.
  - m_last is in cycle T+1+RD_LATENCY+P, where P is the pair count.
  - busy falls on the cycle after the m_last handshake.
- buf_done in the same cycle as the m_last handshake counts as overrun. It is accepted only in IDLE.
- Address outputs are registered. They hold their last value when not issuing.

## Test plan

1. Reset: assert rst_n low with random inputs toggling → every output at its reset value, with no clock edge required.
2. VECTOR_LENGTH = 4; BRAM model with buffer 1 word[i] = 100+i; buf_done with idx 1; m_ready = 1 →
   - First m_valid 4 cycles after buf_done.
   - 10 consecutive beats (0,0), (0,1), …, (3,3) with m_data = {100+a, 100+b}.
   - m_last only on beat 10; buf_sel = 1 throughout.
3. Backpressure: as scenario 2 with default N, m_ready random at 50% →
   - Exactly 528 beats in order, no drop or duplicate.
   - Outputs stable during every stall; FIFO never overflows (assertion).
4. Overrun: second buf_done in READ at beat 50 → overrun high exactly 1 cycle; stream identical to an undisturbed run; busy unaffected.
5. Reset mid-readout after beat 5 → m_valid and busy low asynchronously. A subsequent buf_done (idx 0) yields a full sequence from (0,0) reading buffer 0.
6. Back-to-back buffers: buf_done idx 0, then idx 1 issued the cycle after busy falls → both readouts complete; buf_sel switches 0 → 1; no overrun.
